div_share_ctrl: RTL and testbench

Sequencer/arbiter sharing one iterative divider between the two execute lanes of the dual-issue EXM stage. Each lane drives its usual divider request bus and receives `{result, ok}`. The block grants the divider to one lane at a time and latches the operands. It holds each lane's quotient/remainder until the lane pair advances, so a lane that finished early keeps `ok` high while its partner is still computing.

---
 rtl/div_share_ctrl.sv | 173 +++++++++++++++++
 tb/tb_div_share_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one iterative divider between the two execute lanes of the
//   dual-issue EXM stage. One lane at a time is granted the divider; its
//   operands are latched at grant. Each lane's result is held in a
//   per-lane register until the lane pair advances. This lets a lane that
//   finished early keep ok high while its partner is still dividing.
//
//   Optional feature macro: DIV_SHARE_BYPASS_EN
//     defined   : the owner lane sees {div_result, ok} combinationally in the
//                 div_done cycle. If pipe_adv is high in that same cycle, the
//                 result is consumed directly and done_q is not set.
//     undefined : lane outputs come only from registers (ok one cycle after
//                 div_done). There is no path from the divider to the lane
//                 outputs.
//
//   Ports
//     clk, resetn            clock, synchronous active-low reset
//     l0_div_bus, l1_div_bus lane request {req, use_mod, is_unsigned, src1, src2}
//     l0_div_res, l1_div_res lane response {result, ok}
//     pipe_adv               lane pair leaves EXM; clears both done flags
//     flush                  kills all divide work (highest priority)
//     div_valid/div_ready    operation handshake towards the divider
//     div_mod, div_unsigned  latched op controls
//     div_src1, div_src2     latched operands
//     div_done, div_result   one-cycle completion pulse and its result
//     div_cancel             abort the in-flight operation (flush cycle only)
//     busy                   FSM is not IDLE
//
//   Handshake: div_valid is high for every cycle the FSM sits in ISSUE.
//   div_mod/div_unsigned/div_src* stay constant while div_valid is high.
//   The operation is accepted in the first cycle with div_valid && div_ready.
//   Exactly one div_done pulse is expected per accepted operation.
module div_share_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [DATA_W*2+2:0] l0_div_bus,
    output logic [DATA_W:0]     l0_div_res,
    input  logic [DATA_W*2+2:0] l1_div_bus,
    output logic [DATA_W:0]     l1_div_res,
    input  logic                pipe_adv,
    input  logic                flush,
    output logic                div_valid,
    input  logic                div_ready,
    output logic                div_mod,
    output logic                div_unsigned,
    output logic [DATA_W-1:0]   div_src1,
    output logic [DATA_W-1:0]   div_src2,
    input  logic                div_done,
    input  logic [DATA_W-1:0]   div_result,
    output logic                div_cancel,
    output logic                busy
);

    localparam int REQ_B = 2*DATA_W+2;
    localparam int MOD_B = 2*DATA_W+1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic              owner;       // 0: lane 0 holds the divider, 1: lane 1
    logic [1:0]        done_q;
    logic [DATA_W-1:0] res0_q;
    logic [DATA_W-1:0] res1_q;

    logic              l0_req;
    logic              l1_req;
    logic              l0_pend;
    logic              l1_pend;
    logic              keep_result;
    logic [MOD_B:0]    sel_ops;     // {use_mod, is_unsigned, src1, src2} of the winner

    assign l0_req = l0_div_bus[REQ_B];
    assign l1_req = l1_div_bus[REQ_B];

    // The current owner is never pending again: it is either in flight or done.
    assign l0_pend = l0_req && !done_q[0] && !(busy && !owner);
    assign l1_pend = l1_req && !done_q[1] && !(busy && owner);

    // Lane 0 is older in program order, so it wins a tie.
    assign sel_ops = l0_pend ? l0_div_bus[MOD_B:0] : l1_div_bus[MOD_B:0];

`ifdef DIV_SHARE_BYPASS_EN
    // A result delivered through the bypass in the advance cycle is already
    // consumed by the departing instruction and must not linger in done_q.
    assign keep_result = !pipe_adv;
`else
    assign keep_result = 1'b1;
`endif

    assign busy       = (state != IDLE);
    assign div_valid  = (state == ISSUE);
    assign div_cancel = flush && busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            owner        <= 1'b0;
            done_q       <= 2'b00;
            res0_q       <= '0;
            res1_q       <= '0;
            div_mod      <= 1'b0;
            div_unsigned <= 1'b0;
            div_src1     <= '0;
            div_src2     <= '0;
        end else if (flush) begin
            // A div_done in this cycle is dropped on purpose.
            state  <= IDLE;
            done_q <= 2'b00;
        end else begin
            if (pipe_adv) begin
                done_q <= 2'b00;
            end
            case (state)
                IDLE: begin
                    // Requests seen with pipe_adv belong to the departing pair.
                    if (!pipe_adv && (l0_pend || l1_pend)) begin
                        owner <= !l0_pend;
                        {div_mod, div_unsigned, div_src1, div_src2} <= sel_ops;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (div_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        if (owner) begin
                            res1_q <= div_result;
                        end else begin
                            res0_q <= div_result;
                        end
                        if (keep_result) begin
                            done_q[owner] <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane outputs read zero unless the lane is requesting and has a result.
    always_comb begin
        l0_div_res = '0;
        l1_div_res = '0;
        if (l0_req && done_q[0]) begin
            l0_div_res = {res0_q, 1'b1};
        end
        if (l1_req && done_q[1]) begin
            l1_div_res = {res1_q, 1'b1};
        end
`ifdef DIV_SHARE_BYPASS_EN
        if (state == WAIT && div_done && !flush) begin
            if (!owner && l0_req) begin
                l0_div_res = {div_result, 1'b1};
            end
            if (owner && l1_req) begin
                l1_div_res = {div_result, 1'b1};
            end
        end
`endif
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
`timescale 1ns/1ps
module tb_div_share_ctrl;

    localparam int W   = 32;
    localparam int BW  = 2*W+3;
    localparam int OPW = 2*W+2;
    localparam int CW  = 2*W+2;
`ifdef DIV_SHARE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic         mod;
        logic         uns;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [BW-1:0] l0_div_bus = '0;
    logic [BW-1:0] l1_div_bus = '0;
    logic [W:0]    l0_div_res;
    logic [W:0]    l1_div_res;
    logic          pipe_adv = 1'b0;
    logic          flush = 1'b0;
    logic          div_valid;
    logic          div_ready = 1'b0;
    logic          div_mod;
    logic          div_unsigned;
    logic [W-1:0]  div_src1;
    logic [W-1:0]  div_src2;
    logic          div_done = 1'b0;
    logic [W-1:0]  div_result = '0;
    logic          div_cancel;
    logic          busy;

    always #5 clk = ~clk;

    div_share_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .resetn(resetn),
        .l0_div_bus(l0_div_bus), .l0_div_res(l0_div_res),
        .l1_div_bus(l1_div_bus), .l1_div_res(l1_div_res),
        .pipe_adv(pipe_adv), .flush(flush),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_mod(div_mod), .div_unsigned(div_unsigned),
        .div_src1(div_src1), .div_src2(div_src2),
        .div_done(div_done), .div_result(div_result),
        .div_cancel(div_cancel), .busy(busy)
    );

    // ---------------- scoreboard / reference model ----------------
    int             checks = 0;
    int             failures = 0;
    logic [OPW-1:0] exp_q[$];      // operations the divider should see, in order
    bit             m_req[2];
    bit             m_ok[2];
    op_t            m_op[2];
    logic [W-1:0]   m_res[2];

    task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // What a divider returns: RISC-V style, including divide-by-zero and overflow.
    function automatic logic [W-1:0] ref_div(input logic m, input logic u,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) return m ? a : '1;
        if (u) return m ? (a % b) : (a / b);
        if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return m ? '0 : a;
        return m ? W'(sa % sb) : W'(sa / sb);
    endfunction

    function automatic logic [W-1:0] op_result(input op_t o);
        return ref_div(o.mod, o.uns, o.a, o.b);
    endfunction

    function automatic logic [W:0] model_res(input int i);
        return (m_req[i] && m_ok[i]) ? {m_res[i], 1'b1} : {(W+1){1'b0}};
    endfunction

    function automatic logic [W:0] lane_res(input int k);
        return (k == 1) ? l1_div_res : l0_div_res;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.mod = 1'($urandom_range(0, 1));
        o.uns = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: begin o.a = $urandom; o.b = $urandom; end
            1: begin o.a = $urandom_range(0, 1000); o.b = $urandom_range(1, 20); end
            2: begin o.a = $urandom; o.b = '0; end
            default: begin
                o.a = W'(-int'($urandom_range(0, 1000)));
                o.b = W'(-int'($urandom_range(1, 9)));
            end
        endcase
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_bus(input int k, input logic r, input op_t o);
        if (k == 0) l0_div_bus = {r, o};
        else        l1_div_bus = {r, o};
    endtask

    task automatic check_lanes(input string tag);
        check({tag, "_l0"}, l0_div_res, model_res(0));
        check({tag, "_l1"}, l1_div_res, model_res(1));
    endtask

    // New lane pair enters EXM (also the cycle right after any pipe_adv).
    task automatic start_txn(input bit r0, input bit r1, input op_t o0, input op_t o1);
        next_cycle();
        pipe_adv = 1'b0;
        flush = 1'b0;
        m_ok[0] = 1'b0;
        m_ok[1] = 1'b0;
        m_req[0] = r0;
        m_req[1] = r1;
        m_op[0] = o0;
        m_op[1] = o1;
        set_bus(0, r0, o0);
        set_bus(1, r1, o1);
        exp_q.delete();
        if (r0) exp_q.push_back(o0);
        if (r1) exp_q.push_back(o1);
        settle();
        check("start_valid", div_valid, 1'b0);
        check("start_busy", busy, 1'b0);
        check_lanes("start");
    endtask

    // Acts as the divider for lane k's operation: ISSUE (with wait_rdy stall
    // cycles), accept, lat cycles to div_done, then the cycle after.
    task automatic serve_lane(input int k, input int lat, input int wait_rdy);
        op_t          cap;
        logic [W-1:0] want;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1'b1, 1'b0);
            return;
        end
        want = op_result(m_op[k]);
        for (int w = 0; w <= wait_rdy; w++) begin
            next_cycle();
            div_ready = (w == wait_rdy);
            set_bus(k, 1'b1, rand_op());       // lane bus moves on after grant
            settle();
            check("issue_valid", div_valid, 1'b1);
            check("issue_ops", {div_mod, div_unsigned, div_src1, div_src2}, exp_q[0]);
            check_lanes("issue");
        end
        cap = {div_mod, div_unsigned, div_src1, div_src2};
        void'(exp_q.pop_front());
        for (int t = 1; t < lat; t++) begin
            next_cycle();
            div_ready = 1'b0;
            settle();
            check("wait_valid", div_valid, 1'b0);
            check("wait_busy", busy, 1'b1);
            check_lanes("wait");
        end
        next_cycle();
        div_ready = 1'b0;
        div_done = 1'b1;
        div_result = op_result(cap);
        settle();
        check("done_own", lane_res(k), BYPASS ? {want, 1'b1} : {(W+1){1'b0}});
        check("done_other", lane_res(1 - k), model_res(1 - k));
        next_cycle();
        div_done = 1'b0;
        div_result = $urandom;
        m_ok[k] = 1'b1;
        m_res[k] = want;
        settle();
        check("d1_valid", div_valid, 1'b0);
        check("d1_busy", busy, 1'b0);
        check_lanes("d1");
    endtask

    // Results hold with no reissue, then the pair advances. A lane that had
    // no request may raise one during the advance; it must be ignored.
    task automatic finish_pair();
        next_cycle();
        settle();
        check("no_reissue", div_valid, 1'b0);
        check("hold_busy", busy, 1'b0);
        check_lanes("hold");
        next_cycle();
        pipe_adv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!m_req[i]) set_bus(i, 1'($urandom_range(0, 1)), rand_op());
        end
        settle();
        check_lanes("adv");
    endtask

    task automatic run_pair(input bit r0, input bit r1, input int lat, input int wait_rdy);
        start_txn(r0, r1, rand_op(), rand_op());
        if (r0) serve_lane(0, lat, wait_rdy);
        if (r1) serve_lane(1, lat, wait_rdy);
        finish_pair();
    endtask

    // Flush one cycle before div_done (or together with it). lat >= 2.
    task automatic run_flush(input bit both, input bit done_in_flush, input int lat);
        start_txn(1'b1, both, rand_op(), rand_op());
        if (both) serve_lane(0, lat, 0);
        next_cycle();
        div_ready = 1'b1;
        settle();
        check("fl_valid", div_valid, 1'b1);
        check("fl_ops", {div_mod, div_unsigned, div_src1, div_src2}, exp_q[0]);
        void'(exp_q.pop_front());
        for (int t = 1; t < lat - 1; t++) begin
            next_cycle();
            div_ready = 1'b0;
            settle();
            check("fl_wait_busy", busy, 1'b1);
        end
        next_cycle();
        div_ready = 1'b0;
        flush = 1'b1;
        div_done = done_in_flush;
        div_result = $urandom;
        settle();
        check("fl_cancel", div_cancel, 1'b1);
        check_lanes("fl_cycle");
        m_ok[0] = 1'b0;
        m_ok[1] = 1'b0;
        next_cycle();
        flush = 1'b0;
        div_done = !done_in_flush;             // late completion, must be ignored
        div_result = $urandom;
        settle();
        check("fl_busy", busy, 1'b0);
        check("fl_cancel_off", div_cancel, 1'b0);
        check_lanes("fl_idle");
        next_cycle();
        div_done = 1'b0;
        flush = 1'b1;
        settle();
        check("fl_regrant", div_valid, 1'b1);
        check("fl_cancel2", div_cancel, 1'b1);
        check_lanes("fl_regrant");
        next_cycle();
        flush = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        set_bus(0, 1'b0, rand_op());
        set_bus(1, 1'b0, rand_op());
        settle();
        check("fl_end_busy", busy, 1'b0);
        check("fl_end_cancel", div_cancel, 1'b0);
        check_lanes("fl_end");
        exp_q.delete();
    endtask

    // pipe_adv is only legal with the FSM idle (or, with bypass, in the done cycle).
    always @(negedge clk) begin
        if (resetn && pipe_adv) check("adv_while_busy", busy && !(BYPASS && div_done), 1'b0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    // ---------------- stimulus ----------------
    initial begin
        op_t o_a;
        op_t o_b;

        // Reset held for 3 edges with lane 0 requesting: everything reads 0.
        o_a = '{mod: 1'b0, uns: 1'b0, a: W'(-7), b: W'(2)};
        m_req[0] = 1'b1; m_req[1] = 1'b0;
        m_ok[0] = 1'b0;  m_ok[1] = 1'b0;
        m_op[0] = o_a;   m_op[1] = rand_op();
        set_bus(0, 1'b1, o_a);
        set_bus(1, 1'b0, m_op[1]);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            check("rst_l0", l0_div_res, '0);
            check("rst_l1", l1_div_res, '0);
            check("rst_ctrl", {div_valid, div_mod, div_unsigned, div_cancel, busy}, '0);
            check("rst_src", {div_src1, div_src2}, '0);
        end
        resetn = 1'b1;
        settle();
        check("rel_valid", div_valid, 1'b0);
        exp_q.delete();
        exp_q.push_back(o_a);
        serve_lane(0, 4, 0);
        check("m7_div2", l0_div_res, {32'hFFFF_FFFD, 1'b1});
        finish_pair();

        // Both lanes: 100/7 signed on lane 0, 100%7 unsigned on lane 1.
        o_a = '{mod: 1'b0, uns: 1'b0, a: W'(100), b: W'(7)};
        o_b = '{mod: 1'b1, uns: 1'b1, a: W'(100), b: W'(7)};
        start_txn(1'b1, 1'b1, o_a, o_b);
        serve_lane(0, 3, 0);
        check("q_100_7", l0_div_res, {W'(14), 1'b1});
        serve_lane(1, 3, 0);
        check("r_100_7", l1_div_res, {W'(2), 1'b1});
        check("q_hold", l0_div_res, {W'(14), 1'b1});
        finish_pair();

        // Backpressure: five stall cycles with the lane bus changing.
        run_pair(1'b1, 1'b0, 2, 5);
        run_pair(1'b0, 1'b1, 3, 5);

        // Randomized pairs.
        for (int n = 0; n < 20; n++) begin
            int r;
            r = $urandom_range(1, 3);
            run_pair(r[0], r[1], $urandom_range(1, 6), $urandom_range(0, 3));
        end

        // Flushes in WAIT, single and dual, late done and done-in-flush.
        run_flush(1'b0, 1'b0, 4);
        run_flush(1'b1, 1'b0, 3);
        run_flush(1'b0, 1'b1, 2);
        run_flush(1'b1, 1'b1, $urandom_range(2, 5));

        // Reset in WAIT: back to IDLE, then the still-requesting lane reissues.
        start_txn(1'b0, 1'b1, rand_op(), rand_op());
        next_cycle();
        div_ready = 1'b1;
        settle();
        check("rw_valid", div_valid, 1'b1);
        next_cycle();
        div_ready = 1'b0;
        settle();
        check("rw_busy", busy, 1'b1);
        next_cycle();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        settle();
        check("rw_idle", busy, 1'b0);
        check("rw_src", {div_src1, div_src2}, '0);
        check_lanes("rw");
        exp_q.delete();
        exp_q.push_back(m_op[1]);
        serve_lane(1, 2, 1);
        finish_pair();

`ifdef DIV_SHARE_BYPASS_EN
        // Bypass: pipe_adv together with div_done consumes the result directly.
        start_txn(1'b1, 1'b0, rand_op(), rand_op());
        next_cycle();
        div_ready = 1'b1;
        settle();
        check("bp_valid", div_valid, 1'b1);
        void'(exp_q.pop_front());
        next_cycle();
        div_ready = 1'b0;
        settle();
        next_cycle();
        div_done = 1'b1;
        div_result = op_result(m_op[0]);
        pipe_adv = 1'b1;
        settle();
        check("bp_ok_d", l0_div_res, {op_result(m_op[0]), 1'b1});
        next_cycle();
        div_done = 1'b0;
        pipe_adv = 1'b0;
        settle();
        check("bp_no_done", l0_div_res, '0);
        check("bp_idle", busy, 1'b0);
        exp_q.push_back(m_op[0]);
        serve_lane(0, 2, 0);
        finish_pair();
`endif

        next_cycle();
        pipe_adv = 1'b0;
        settle();
        check("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
